sliding_window_frame_arbiter: RTL

Frame-level round-robin arbiter that lets `NUM_REQ` independent pixel streams share one `sliding_window` instance. The window buffer holds per-frame state, so ownership is granted for a whole frame. The arbiter routes one requester's input beats into the window, counts the frame's input and output beats, and tags every output window with its owner and a last-of-frame flag. It re-arbitrates only after the window has fully drained.

---
 rtl/sliding_window_pkg.sv | 27 ++
 rtl/sliding_window_frame_arbiter_rr_pick.sv | 28 ++
 rtl/sliding_window_frame_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sliding_window_pkg.sv
// Shared types and frame-geometry helpers for the sliding-window block family.
package sliding_window_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } sw_arb_state_t;

  // Number of input beats in one unpadded frame (channel fastest, then x, then y).
  function automatic int sw_in_beats(input int img_w, input int img_h, input int chans);
    return img_w * img_h * chans;
  endfunction

  // Number of windows the padded frame produces, counted per channel.
  function automatic int sw_out_beats(input int img_w, input int img_h, input int chans,
                                      input int kern_w, input int kern_h,
                                      input int pad_w, input int pad_h,
                                      input int stride);
    int padded_w;
    int padded_h;
    padded_w = img_w + 2 * pad_w;
    padded_h = img_h + 2 * pad_h;
    return ((padded_h - kern_h) / stride + 1) * ((padded_w - kern_w) / stride + 1) * chans;
  endfunction

endpackage

// File: rtl/sliding_window_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or above start, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(start) + i) % NUM_REQ);
      if (grant == '0 && valid[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/sliding_window_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one sliding_window between NUM_REQ streams.
module sliding_window_frame_arbiter
  import sliding_window_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int IMG_WIDTH      = 4,
  parameter int IMG_HEIGHT     = 3,
  parameter int CHANNELS       = 2,
  parameter int KERNEL_WIDTH   = 3,
  parameter int KERNEL_HEIGHT  = 2,
  parameter int PADDING_WIDTH  = 1,
  parameter int PADDING_HEIGHT = 1,
  parameter int STRIDE         = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      req_data [NUM_REQ],
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_WIDTH-1:0]      win_in_data,
  output logic                       win_in_valid,
  input  logic                       win_in_ready,
  input  logic                       win_out_valid,
  output logic                       win_out_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_REQ)-1:0] out_owner,
  output logic                       out_last,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int IDX_W     = $clog2(NUM_REQ);
  localparam int IN_BEATS  = sw_in_beats(IMG_WIDTH, IMG_HEIGHT, CHANNELS);
  localparam int OUT_BEATS = sw_out_beats(IMG_WIDTH, IMG_HEIGHT, CHANNELS,
                                          KERNEL_WIDTH, KERNEL_HEIGHT,
                                          PADDING_WIDTH, PADDING_HEIGHT, STRIDE);
  localparam int ICNT_W    = $clog2(IN_BEATS + 1);
  localparam int OCNT_W    = $clog2(OUT_BEATS + 1);

  localparam logic [ICNT_W-1:0] IN_LAST  = ICNT_W'(IN_BEATS - 1);
  localparam logic [OCNT_W-1:0] OUT_LAST = OCNT_W'(OUT_BEATS - 1);
  localparam logic [IDX_W-1:0]  REQ_LAST = IDX_W'(NUM_REQ - 1);

  sw_arb_state_t     state_q, state_d;
  logic [IDX_W-1:0]  owner_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [ICNT_W-1:0] in_cnt_q;
  logic [OCNT_W-1:0] out_cnt_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               grant_now;
  logic               in_hs;
  logic               out_hs;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid (req_valid),
    .start (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign grant_now = (state_q == IDLE) && (pick_grant != '0);
  assign busy      = (state_q != IDLE);
  assign out_owner = owner_q;

  always_comb begin
    state_d       = state_q;
    req_ready     = '0;
    win_in_data   = '0;
    win_in_valid  = 1'b0;
    win_out_ready = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    frame_done    = 1'b0;
    in_hs         = 1'b0;
    out_hs        = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_now) state_d = STREAM;
      end
      STREAM: begin
        win_in_data        = req_data[owner_q];
        win_in_valid       = req_valid[owner_q];
        req_ready[owner_q] = win_in_ready;
        in_hs              = req_valid[owner_q] && win_in_ready;
        if (in_hs && in_cnt_q == IN_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = DRAIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A stray window output seen while IDLE is held off by keeping win_out_ready low.
    if (state_q != IDLE) begin
      out_valid     = win_out_valid;
      win_out_ready = out_ready;
      out_last      = (out_cnt_q == OUT_LAST);
      out_hs        = win_out_valid && out_ready;
      frame_done    = out_hs && out_last;
      // The final output wins over a coincident final input: go straight to IDLE.
      if (frame_done) state_d = IDLE;
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) only; the comb block above uses blocking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_now) begin
        owner_q   <= pick_idx;
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        if (in_hs)  in_cnt_q  <= in_cnt_q + 1'b1;
        if (out_hs) out_cnt_q <= out_cnt_q + 1'b1;
      end
      if (frame_done) rr_ptr_q <= (owner_q == REQ_LAST) ? '0 : owner_q + 1'b1;
    end
  end

endmodule
